u109_pci_arbiter: RTL
=====================

Name: u109_pci_arbiter

Overview:
- Central PCI bus arbiter for the U109 bridge: shares the PCI bus between the host bridge (agent 0) and the slot masters (agents 1..NUM_AGENTS-1) using REQn/GNTn pairs.
- Uses round-robin with bus parking on the host bridge, a grant-acceptance timeout, and a forced-release input driven by the bridge register PCI reset bit.
- Sits beside the bridge register block and the PCI master/target sequencers.

Parameters:
- NUM_AGENTS, 5, number of REQn/GNTn pairs; agent 0 is the host bridge and the park target.
- OWNER_W, 3, width of OWNER; must satisfy 2^OWNER_W >= NUM_AGENTS.
- GNT_TIMEOUT_CLKS, 16, idle-bus clocks a granted agent has to assert FRAMEn before its grant is revoked.

Ports:
- CLK40  in  1  bridge/PCI clock; all logic on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- REQn  in  NUM_AGENTS  active-low bus requests, synchronous to CLK40; bit 0 = host bridge.
- FRAMEn  in  1  PCI FRAME#, sampled.
- IRDYn  in  1  PCI IRDY#, sampled.
- PCI_RESET  in  1  active-high; from bridge register bit 31 at offset 0x00.
- GNTn  out  NUM_AGENTS  active-low grants; at most one bit low at any time.
- OWNER  out  OWNER_W  index of the current or last-granted agent.
- BUS_PARKED  out  1  high while the host holds the grant with no request pending.
- GNT_TIMEOUT  out  1  one-clock pulse when a grant is revoked for non-use.

Behaviour:
- Bus idle: IDLE = FRAMEn & IRDYn, as sampled on the current edge.
- Reset (RESETn low, asynchronous): GNTn all 1, OWNER 0, BUS_PARKED 0, GNT_TIMEOUT 0, timeout counter 0, state HOLD.
- All outputs are registered.

States:
- HOLD
  - All GNTn high.
  - Leave only when PCI_RESET=0 and IDLE=1.
  - Then go to SWITCH with search origin = OWNER.
- PARK
  - GNTn[0]=0, OWNER=0, BUS_PARKED=1.
  - Any REQn[j]=0 with j!=0: deassert GNTn[0] and go to SWITCH.
  - Host REQn[0]=0: enter GRANT for agent 0 directly, with no dead cycle.
  - Parked host never times out.
- GRANT
  - GNTn[OWNER]=0, BUS_PARKED=0.
  - Counter increments each clock while IDLE=1.
  - FRAMEn=0: go to BUSY, clear counter.
  - Owner deasserts REQn before FRAMEn: drop grant, go to SWITCH.
  - Counter reaches GNT_TIMEOUT_CLKS-1 with FRAMEn still high: drop grant, pulse GNT_TIMEOUT on the next clock, go to SWITCH.
- BUSY
  - Owner transaction in progress.
  - Any other REQn low: deassert GNTn[OWNER] (the owner's latency timer terminates it) and go to SWITCH.
  - Otherwise keep the grant. On IDLE=1: owner REQn low -> GRANT (counter 0); owner REQn high -> SWITCH.
- SWITCH
  - All GNTn high for at least one clock, and until IDLE=1.
  - Then search REQn from (OWNER+1) mod NUM_AGENTS, wrapping, for the first low bit.
  - Found: GRANT that agent and set OWNER.
  - None found: PARK.

Boundary conditions:
- PCI_RESET=1 in any state: all GNTn high on the next edge; go to HOLD; counter cleared. It overrides every other transition.
- Round-robin fairness: an agent that just finished is searched last. With every REQn low, grants cycle 1,2,3,4,0,1...
- Simultaneous timeout and FRAMEn assertion on the same edge: FRAMEn wins; no pulse; go to BUSY.
- Owner re-requests in the same clock it is revoked: it is searched last.
- At most one GNTn low at any time. Every change of grant between two different agents passes through at least one all-high clock. The only exception is PARK->GRANT for agent 0, which keeps the same grant.
- Async reset mid-transaction: GNTn all high immediately, without waiting for the clock.

Test Plan:
- Reset, then PCI_RESET=0, REQn=5'b11111, bus idle -> after HOLD and one SWITCH clock, GNTn=5'b11110, BUS_PARKED=1, OWNER=0.
- Parked; REQn=5'b11011 -> next clock GNTn=5'b11111; following clock GNTn=5'b11011, OWNER=2. FRAMEn low 2 clocks later -> BUSY; grant held while no other request.
- GNTn=5'b11101 (agent 1), FRAMEn held high -> GNTn[1] rises after 16 idle clocks; GNT_TIMEOUT pulses exactly once; no other REQn low -> returns to PARK (GNTn=5'b11110).
- REQn=5'b00000, each owner asserts FRAMEn for 3 clocks when granted -> OWNER sequence 1,2,3,4,0,1; never two GNTn bits low; at least one all-high clock between grants.
- Agent 3 in BUSY (FRAMEn low); PCI_RESET pulsed high 1 clock -> GNTn=5'b11111 next edge; held until PCI_RESET=0 and FRAMEn=IRDYn=1, then grants resume from agent 4.
- Agent 2 in GRANT; RESETn driven low between clock edges -> GNTn=5'b11111 and OWNER=0 before the next rising edge.

Source files
------------

// File: rtl/u109_pci_arbiter.sv
// rtl/u109_pci_arbiter.sv - Round-robin PCI bus arbiter with host parking and grant timeout
// Every change of grant between two agents passes through an all-high clock.
module u109_pci_arbiter #(
  parameter int NUM_AGENTS       = 5,
  parameter int OWNER_W          = 3,
  parameter int GNT_TIMEOUT_CLKS = 16
) (
  input  logic                  CLK40,
  input  logic                  RESETn,
  input  logic [NUM_AGENTS-1:0] REQn,
  input  logic                  FRAMEn,
  input  logic                  IRDYn,
  input  logic                  PCI_RESET,
  output logic [NUM_AGENTS-1:0] GNTn,
  output logic [OWNER_W-1:0]    OWNER,
  output logic                  BUS_PARKED,
  output logic                  GNT_TIMEOUT
);
  localparam int CNT_W = $clog2(GNT_TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {S_HOLD, S_PARK, S_GRANT, S_BUSY, S_SWITCH} state_t;

  state_t                  state_q, state_d;
  logic [NUM_AGENTS-1:0]   gntn_q, gntn_d;
  logic [OWNER_W-1:0]      owner_q, owner_d;
  logic                    parked_q, parked_d;
  logic                    tmo_q, tmo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    idle;
  logic                    own_req;
  logic                    other_req;
  logic [NUM_AGENTS-1:0]   own_mask;
  logic                    found;
  logic [OWNER_W-1:0]      pick;
  logic [OWNER_W-1:0]      cand;

  assign idle      = FRAMEn & IRDYn;
  assign own_mask  = NUM_AGENTS'(1) << owner_q;
  assign own_req   = ~REQn[owner_q];
  assign other_req = |(~REQn & ~own_mask);

  // Walk downward so the nearest requester after the owner is the one kept;
  // the owner itself is the last candidate.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = NUM_AGENTS; i >= 1; i--) begin
      cand = OWNER_W'((int'(owner_q) + i) % NUM_AGENTS);
      if (!REQn[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gntn_d   = gntn_q;
    owner_d  = owner_q;
    parked_d = 1'b0;
    tmo_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_HOLD: begin
        gntn_d = '1;
        if (idle) state_d = S_SWITCH;
      end
      S_PARK: begin
        if (other_req) begin
          state_d = S_SWITCH;
          gntn_d  = '1;
        end else if (!REQn[0]) begin
          state_d = S_GRANT;
          cnt_d   = '0;
        end else begin
          parked_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (!FRAMEn) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else if (!own_req) begin
          state_d = S_SWITCH;
          gntn_d  = '1;
        end else if (idle) begin
          if (cnt_q == CNT_W'(GNT_TIMEOUT_CLKS - 1)) begin
            state_d = S_SWITCH;
            gntn_d  = '1;
            tmo_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (other_req) begin
          state_d = S_SWITCH;
          gntn_d  = '1;
        end else if (idle) begin
          if (own_req) begin
            state_d = S_GRANT;
            cnt_d   = '0;
          end else begin
            state_d = S_SWITCH;
            gntn_d  = '1;
          end
        end
      end
      S_SWITCH: begin
        gntn_d = '1;
        if (idle) begin
          if (found) begin
            state_d = S_GRANT;
            owner_d = pick;
            gntn_d  = ~(NUM_AGENTS'(1) << pick);
            cnt_d   = '0;
          end else begin
            state_d  = S_PARK;
            owner_d  = '0;
            gntn_d   = ~NUM_AGENTS'(1);
            parked_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_HOLD;
        gntn_d  = '1;
      end
    endcase
    if (PCI_RESET) begin
      state_d  = S_HOLD;
      gntn_d   = '1;
      cnt_d    = '0;
      parked_d = 1'b0;
      tmo_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= S_HOLD;
      gntn_q   <= '1;
      owner_q  <= '0;
      parked_q <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gntn_q   <= gntn_d;
      owner_q  <= owner_d;
      parked_q <= parked_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign GNTn        = gntn_q;
  assign OWNER       = owner_q;
  assign BUS_PARKED  = parked_q;
  assign GNT_TIMEOUT = tmo_q;
endmodule
